// File: rtl/icache_tag_pkg.sv
// Shared constants, tag-entry layout, state encoding and address helpers for the I-cache tag controller.
package icache_tag_pkg;

    localparam int unsigned ICACHE_ADDR_W = 32;
    localparam int unsigned ICACHE_OFF_W  = 5;
    localparam int unsigned ICACHE_IDX_W  = 4;
    localparam int unsigned ICACHE_TAG_W  = ICACHE_ADDR_W - ICACHE_OFF_W - ICACHE_IDX_W;
    localparam int unsigned ICACHE_WORD_W = ICACHE_TAG_W + 1;
    localparam int unsigned ICACHE_SETS   = 1 << ICACHE_IDX_W;

    // One macro word: valid bit on top, tag below.
    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
    } icache_tag_entry_t;

    typedef enum logic [1:0] {
        SWEEP,
        IDLE,
        LOOKUP
    } icache_state_t;

endpackage

// File: rtl/icache_tag_ctrl_if.sv
// Fetch-side lookup/response and refill handshake bundle.
interface icache_tag_ctrl_if;
    import icache_tag_pkg::*;

    logic                     req_valid;
    logic [ICACHE_ADDR_W-1:0] req_addr;
    logic                     req_ready;
    logic                     resp_valid;
    logic                     resp_hit;
    logic [ICACHE_ADDR_W-1:0] resp_addr;
    logic                     fill_valid;
    logic [ICACHE_ADDR_W-1:0] fill_addr;
    logic                     fill_ready;

    // Fetch unit / refill engine side.
    modport master (
        output req_valid, req_addr, fill_valid, fill_addr,
        input  req_ready, resp_valid, resp_hit, resp_addr, fill_ready
    );

    // Tag controller side.
    modport slave (
        input  req_valid, req_addr, fill_valid, fill_addr,
        output req_ready, resp_valid, resp_hit, resp_addr, fill_ready
    );

endinterface

// File: rtl/icache_tag_ctrl.sv
// I-cache tag controller: invalidate sweep, refill writes and 1-cycle hit/miss lookups
// in front of a registered-input, combinational-output single-port tag SRAM.
module icache_tag_ctrl
    import icache_tag_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    icache_tag_ctrl_if.slave         bus,
    input  logic                     flush,
    output logic                     busy,
    output logic                     tag_csb0,
    output logic                     tag_web0,
    output logic [ICACHE_IDX_W-1:0]  tag_addr0,
    output logic [ICACHE_WORD_W-1:0] tag_din0,
    input  logic [ICACHE_WORD_W-1:0] tag_dout0
);

    localparam int unsigned TAG_LSB = ICACHE_OFF_W + ICACHE_IDX_W;
    localparam logic [ICACHE_IDX_W-1:0] CNT_LAST = ICACHE_IDX_W'(ICACHE_SETS - 1);

    icache_state_t             state_q, state_d;
    logic [ICACHE_IDX_W-1:0]   cnt_q, cnt_d;
    logic [ICACHE_TAG_W-1:0]   tag_q, tag_d;
    logic [ICACHE_ADDR_W-1:0]  addr_q, addr_d;

    icache_tag_entry_t         entry_rd;
    icache_tag_entry_t         entry_wr;
    logic [ICACHE_IDX_W-1:0]   fill_idx;
    logic [ICACHE_IDX_W-1:0]   req_idx;
    logic [ICACHE_TAG_W-1:0]   req_tag;

    // Address field extraction and entry packing.
    always_comb begin
        fill_idx       = bus.fill_addr[ICACHE_OFF_W +: ICACHE_IDX_W];
        req_idx        = bus.req_addr[ICACHE_OFF_W +: ICACHE_IDX_W];
        req_tag        = bus.req_addr[TAG_LSB +: ICACHE_TAG_W];
        entry_rd       = icache_tag_entry_t'(tag_dout0);
        entry_wr.valid = 1'b1;
        entry_wr.tag   = bus.fill_addr[TAG_LSB +: ICACHE_TAG_W];
    end

    // State, sweep counter and captured lookup; reset restarts the sweep and drops any pending response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SWEEP;
            cnt_q   <= '0;
            tag_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            addr_q  <= addr_d;
        end
    end

    // Next state, macro control and handshake/response outputs; priority flush > fill > request.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        tag_d          = tag_q;
        addr_d         = addr_q;
        busy           = 1'b0;
        bus.req_ready  = 1'b0;
        bus.fill_ready = 1'b0;
        bus.resp_valid = 1'b0;
        bus.resp_hit   = 1'b0;
        bus.resp_addr  = '0;
        tag_csb0       = 1'b1;
        tag_web0       = 1'b1;
        tag_addr0      = '0;
        tag_din0       = '0;

        if (rst) begin
            busy = 1'b1;
        end else begin
            case (state_q)
                SWEEP: begin
                    busy      = 1'b1;
                    tag_csb0  = 1'b0;
                    tag_web0  = 1'b0;
                    tag_addr0 = cnt_q;
                    cnt_d     = ICACHE_IDX_W'(cnt_q + ICACHE_IDX_W'(1));
                    if (cnt_q == CNT_LAST) begin
                        state_d = IDLE;
                    end
                end

                IDLE, LOOKUP: begin
                    if (state_q == LOOKUP) begin
                        bus.resp_valid = 1'b1;
                        bus.resp_hit   = entry_rd.valid && (entry_rd.tag == tag_q);
                        bus.resp_addr  = addr_q;
                    end
                    state_d        = IDLE;
                    bus.fill_ready = !flush;
                    bus.req_ready  = !flush && !bus.fill_valid;

                    if (flush) begin
                        state_d = SWEEP;
                        cnt_d   = '0;
                    end else if (bus.fill_valid) begin
                        tag_csb0  = 1'b0;
                        tag_web0  = 1'b0;
                        tag_addr0 = fill_idx;
                        tag_din0  = entry_wr;
                    end else if (bus.req_valid) begin
                        tag_csb0  = 1'b0;
                        tag_addr0 = req_idx;
                        tag_d     = req_tag;
                        addr_d    = bus.req_addr;
                        state_d   = LOOKUP;
                    end
                end

                default: begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_icache_tag_ctrl.sv
// Directed bench for icache_tag_ctrl with a behavioural tag SRAM and a response scoreboard.
module tb_icache_tag_ctrl;
    import icache_tag_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        busy;
    logic        tag_csb0;
    logic        tag_web0;
    logic [3:0]  tag_addr0;
    logic [23:0] tag_din0;
    logic [23:0] tag_dout0;

    icache_tag_ctrl_if bus();

    icache_tag_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .flush     (flush),
        .busy      (busy),
        .tag_csb0  (tag_csb0),
        .tag_web0  (tag_web0),
        .tag_addr0 (tag_addr0),
        .tag_din0  (tag_din0),
        .tag_dout0 (tag_dout0)
    );

    always #5 clk = ~clk;

    // Tag SRAM: inputs registered each edge, write committed one edge later, read output combinational.
    logic [23:0] mem [16];
    logic        m_csb  = 1'b1;
    logic        m_web  = 1'b1;
    logic [3:0]  m_addr = 4'd0;
    logic [23:0] m_din  = 24'd0;

    always @(posedge clk) begin
        if (!m_csb && !m_web) mem[m_addr] <= m_din;
        m_csb  <= tag_csb0;
        m_web  <= tag_web0;
        m_addr <= tag_addr0;
        m_din  <= tag_din0;
    end

    assign tag_dout0 = mem[m_addr];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference tag table, updated when stimulus is driven.
    logic        ref_valid [16];
    logic [22:0] ref_tag   [16];

    function automatic logic ref_hit(input logic [31:0] a);
        logic [3:0] idx;
        idx = a[8:5];
        return ref_valid[idx] && (ref_tag[idx] == a[31:9]);
    endfunction

    task automatic ref_clear();
        for (int i = 0; i < 16; i++) begin
            ref_valid[i] = 1'b0;
            ref_tag[i]   = 23'd0;
        end
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        hit;
        int          due;
    } exp_t;

    exp_t sb [$];

    int n_asrt = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: each response must arrive exactly in its due cycle with the expected payload.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() != 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("resp_missing", 32'(bus.resp_valid), 32'd1);
        end
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("resp_valid", 32'(bus.resp_valid), 32'd1);
            if (bus.resp_valid) begin
                chk("resp_addr", bus.resp_addr, e.addr);
                chk("resp_hit", 32'(bus.resp_hit), 32'(e.hit));
            end
        end else if (bus.resp_valid) begin
            chk("resp_spurious", 32'(bus.resp_valid), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clk);
    endtask

    task automatic idle();
        bus.req_valid  = 1'b0;
        bus.fill_valid = 1'b0;
        flush          = 1'b0;
    endtask

    task automatic issue_req(input logic [31:0] a);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'd1);
        sb.push_back('{addr: a, hit: ref_hit(a), due: cyc + 1});
    endtask

    task automatic issue_fill(input logic [31:0] a);
        bus.fill_valid = 1'b1;
        bus.fill_addr  = a;
        #1;
        chk("fill_ready", 32'(bus.fill_ready), 32'd1);
        ref_valid[a[8:5]] = 1'b1;
        ref_tag[a[8:5]]   = a[31:9];
    endtask

    task automatic check_reset_outputs();
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_fill_ready", 32'(bus.fill_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_hit", 32'(bus.resp_hit), 32'd0);
        chk("rst_resp_addr", bus.resp_addr, 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_csb0", 32'(tag_csb0), 32'd1);
        chk("rst_web0", 32'(tag_web0), 32'd1);
        chk("rst_addr0", 32'(tag_addr0), 32'd0);
        chk("rst_din0", 32'(tag_din0), 32'd0);
    endtask

    // Called in the first cycle of a sweep; checks all 16 clearing writes and the return to idle.
    task automatic check_sweep();
        for (int i = 0; i < 16; i++) begin
            chk("sweep_csb0", 32'(tag_csb0), 32'd0);
            chk("sweep_web0", 32'(tag_web0), 32'd0);
            chk("sweep_addr0", 32'(tag_addr0), 32'(i));
            chk("sweep_din0", 32'(tag_din0), 32'd0);
            chk("sweep_busy", 32'(busy), 32'd1);
            chk("sweep_req_ready", 32'(bus.req_ready), 32'd0);
            step();
        end
        chk("sweep_done_busy", 32'(busy), 32'd0);
        chk("sweep_done_req_ready", 32'(bus.req_ready), 32'd1);
        ref_clear();
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_addr   = 32'd0;
        bus.fill_valid = 1'b0;
        bus.fill_addr  = 32'd0;
        // Stale valid contents so that a missing clear would show up as a hit.
        for (int i = 0; i < 16; i++) mem[i] = {1'b1, 23'h400000};
        mem[15] = 24'h800000;
        ref_clear();

        repeat (2) step();
        check_reset_outputs();

        // Reset release: sweep, then first-idle-cycle lookup to index 15 sees the cleared entry.
        rst = 1'b0;
        #1;
        check_sweep();
        issue_req(32'h0000_01E0);
        step();
        idle();
        step();

        // Fill followed immediately by lookup hits; same index, other tag misses.
        issue_fill(32'h8000_0040);
        step();
        bus.fill_valid = 1'b0;
        issue_req(32'h8000_0040);
        step();
        issue_req(32'h9000_0040);
        step();
        idle();
        step();

        // Back-to-back lookups: hit then miss.
        issue_req(32'h8000_0040);
        step();
        issue_req(32'h8000_0060);
        step();
        idle();
        step();

        // Fill and request together: fill wins, request accepted next cycle and hits.
        bus.fill_valid = 1'b1;
        bus.fill_addr  = 32'h1234_5680;
        bus.req_valid  = 1'b1;
        bus.req_addr   = 32'h1234_5680;
        #1;
        chk("collide_req_ready", 32'(bus.req_ready), 32'd0);
        chk("collide_fill_ready", 32'(bus.fill_ready), 32'd1);
        chk("collide_web0", 32'(tag_web0), 32'd0);
        chk("collide_din0", 32'(tag_din0), 32'h89_1A2B);
        ref_valid[4] = 1'b1;
        ref_tag[4]   = 23'h091A2B;
        step();
        bus.fill_valid = 1'b0;
        issue_req(32'h1234_5680);
        step();
        idle();
        step();

        // Make index 15 valid, then flush in the LOOKUP cycle of a hitting request.
        issue_fill(32'h0000_01E0);
        step();
        bus.fill_valid = 1'b0;
        issue_req(32'h0000_01E0);
        step();
        idle();
        flush = 1'b1;
        #1;
        chk("flush_req_ready", 32'(bus.req_ready), 32'd0);
        chk("flush_fill_ready", 32'(bus.fill_ready), 32'd0);
        step();
        flush = 1'b0;
        ref_clear();

        // Partial sweep with an ignored flush, then reset mid-sweep.
        for (int i = 0; i < 4; i++) begin
            chk("flush_sweep_addr0", 32'(tag_addr0), 32'(i));
            chk("flush_sweep_busy", 32'(busy), 32'd1);
            flush = (i == 2);
            step();
        end
        flush = 1'b0;
        chk("flush_ignored_addr0", 32'(tag_addr0), 32'd4);
        rst = 1'b1;
        #1;
        check_reset_outputs();
        step();
        rst = 1'b0;
        #1;
        check_sweep();

        // Everything filled before the flush now misses.
        issue_req(32'h0000_01E0);
        step();
        issue_req(32'h8000_0040);
        step();
        issue_req(32'h1234_5680);
        step();
        idle();
        step();
        step();

        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
